// File: rtl/y86_bus_mem.sv
// Byte-addressed memory responder for the y86 core bus, with a byte-wide program loader.
// Optional bus traffic counters are enabled by defining Y86_MEM_STATS_EN.
module y86_bus_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   bus_A,
  input  logic [31:0]   bus_out,
  input  logic          bus_RE,
  input  logic          bus_WE,
  output logic [31:0]   bus_in,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          cpu_rst,
  output logic          err,
  output logic [1:0]    err_code
`ifdef Y86_MEM_STATS_EN
  ,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
`endif
);

  typedef enum logic [1:0] {LOAD, RUN, ERR} state_t;

  localparam logic [31:0] LAST_A = 32'(DEPTH - 4);

  state_t       state, state_next;
  logic [7:0]   mem [DEPTH];
  logic         in_range, ld_in_range;
  logic [AW-1:0] a0;
  logic         ld_we, wr_ok, rd_ok, fault;
  logic [1:0]   fault_code;

  // Full 32-bit compare so high address bits can never alias into the array.
  assign in_range    = (bus_A <= LAST_A);
  assign ld_in_range = (32'(ld_addr) < 32'(DEPTH));
  assign a0          = bus_A[AW-1:0];

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    bus_in     = '0;
    ld_ready   = 1'b0;
    ld_we      = 1'b0;
    wr_ok      = 1'b0;
    rd_ok      = 1'b0;
    fault      = 1'b0;
    fault_code = 2'd0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ld_we = ld_in_range;
          if (ld_last) state_next = RUN;
        end
      end
      RUN: begin
        if (bus_RE && bus_WE) begin
          fault      = 1'b1;
          fault_code = 2'd2;
          state_next = ERR;
        end else if ((bus_RE || bus_WE) && !in_range) begin
          fault      = 1'b1;
          fault_code = 2'd1;
          state_next = ERR;
        end else if (bus_RE) begin
          rd_ok  = 1'b1;
          bus_in = {mem[a0 + AW'(3)], mem[a0 + AW'(2)], mem[a0 + AW'(1)], mem[a0]};
        end else if (bus_WE) begin
          wr_ok = 1'b1;
        end
      end
      ERR:     state_next = ERR;
      default: state_next = LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      cpu_rst  <= 1'b1;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      state   <= state_next;
      cpu_rst <= (state_next == LOAD);
      if (fault) begin
        err      <= 1'b1;
        err_code <= fault_code;
      end
    end
  end

  // NOTE: the array has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (wr_ok) begin
      mem[a0]          <= bus_out[7:0];
      mem[a0 + AW'(1)] <= bus_out[15:8];
      mem[a0 + AW'(2)] <= bus_out[23:16];
      mem[a0 + AW'(3)] <= bus_out[31:24];
    end
  end

`ifdef Y86_MEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_ok && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr_ok && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_bus_mem.sv
// Randomized self-checking bench for y86_bus_mem against a byte-array reference model.
module tb_y86_bus_mem;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   bus_A = '0, bus_out = '0;
  logic          bus_RE = 1'b0, bus_WE = 1'b0;
  logic [31:0]   bus_in;
  logic          ld_valid = 1'b0, ld_last = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          cpu_rst, err;
  logic [1:0]    err_code;
`ifdef Y86_MEM_STATS_EN
  logic [15:0]   rd_count, wr_count;
`endif

  y86_bus_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_out(bus_out), .bus_RE(bus_RE),
    .bus_WE(bus_WE), .bus_in(bus_in), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .cpu_rst(cpu_rst),
    .err(err), .err_code(err_code)
`ifdef Y86_MEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {M_LOAD, M_RUN, M_ERR} mstate_t;
  logic [7:0] m_mem [DEPTH];
  mstate_t    m_state = M_LOAD;
  int         m_err_code = 0;
  int         m_rd = 0, m_wr = 0;
  int         total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int i = int'(a);
    return {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
  endfunction

  task automatic check_regs();
    check("err", err, (m_err_code != 0) ? 1 : 0);
    check("err_code", err_code, m_err_code);
`ifdef Y86_MEM_STATS_EN
    check("rd_count", rd_count, m_rd);
    check("wr_count", wr_count, m_wr);
`endif
  endtask

  // Called at posedge+1; leaves at posedge+1 with rst released.
  task automatic do_reset();
    rst = 1'b1; bus_RE = 1'b1; bus_WE = 1'b0; bus_A = 32'd0; ld_valid = 1'b0;
    #1;
    m_state = M_LOAD; m_err_code = 0; m_rd = 0; m_wr = 0;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_bus_in", bus_in, 0);
    check_regs();
    @(posedge clk); #1;
    rst = 1'b0; bus_RE = 1'b0;
  endtask

  task automatic load_byte(input int addr, input logic [7:0] d, input bit last, input bit valid);
    ld_valid = valid; ld_addr = addr[AW-1:0]; ld_data = d; ld_last = last;
    bus_RE = 1'($urandom_range(0, 1)); bus_WE = 1'($urandom_range(0, 1));
    bus_A = $urandom_range(0, DEPTH + 50); bus_out = $urandom;
    @(negedge clk);
    check("load_ld_ready", ld_ready, 1);
    check("load_cpu_rst", cpu_rst, 1);
    check("load_bus_in", bus_in, 0);
    @(posedge clk); #1;
    if (valid) begin
      if (addr < DEPTH) m_mem[addr] = d;
      if (last) m_state = M_RUN;
    end
    ld_valid = 1'b0; ld_last = 1'b0; bus_RE = 1'b0; bus_WE = 1'b0;
    check("load_cpu_rst_after", cpu_rst, (m_state == M_LOAD) ? 1 : 0);
    check_regs();
  endtask

  task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input bit re, input bit we,
                        output logic [31:0] seen);
    bit ok;
    logic [31:0] exp;
    bus_A = a; bus_out = d; bus_RE = re; bus_WE = we;
    ld_valid = 1'($urandom_range(0, 1)); ld_last = 1'($urandom_range(0, 1));
    ld_addr = AW'($urandom); ld_data = 8'($urandom);
    ok  = (a <= 32'(DEPTH - 4));
    exp = (m_state == M_RUN && re && !we && ok) ? m_read(a) : 32'd0;
    @(negedge clk);
    seen = bus_in;
    check("bus_in", bus_in, exp);
    check("run_ld_ready", ld_ready, 0);
    check("run_cpu_rst", cpu_rst, 0);
    @(posedge clk); #1;
    if (m_state == M_RUN) begin
      if (re && we) begin
        m_state = M_ERR; m_err_code = 2;
      end else if ((re || we) && !ok) begin
        m_state = M_ERR; m_err_code = 1;
      end else if (re) begin
        if (m_rd < 16'hFFFF) m_rd++;
      end else if (we) begin
        for (int i = 0; i < 4; i++) m_mem[int'(a) + i] = d[8*i +: 8];
        if (m_wr < 16'hFFFF) m_wr++;
      end
    end
    bus_RE = 1'b0; bus_WE = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    check_regs();
  endtask

  task automatic random_op();
    int r = $urandom_range(0, 99);
    logic [31:0] a, seen;
    int s = $urandom_range(0, 99);
    if (s < 90)      a = $urandom_range(0, DEPTH - 4);
    else if (s < 95) a = $urandom_range(DEPTH - 3, DEPTH + 60);
    else             a = $urandom | 32'h1000_0000;
    if (r < 45)      bus_op(a, $urandom, 1'b1, 1'b0, seen);
    else if (r < 85) bus_op(a, $urandom, 1'b0, 1'b1, seen);
    else if (r < 97) bus_op(a, $urandom, 1'b0, 1'b0, seen);
    else             bus_op(a, $urandom, 1'b1, 1'b1, seen);
  endtask

  initial begin
    logic [31:0] seen;
    #2;
    do_reset();

    // Fill the whole array through the loader, with idle (invalid) cycles mixed in.
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 7) == 0) load_byte($urandom_range(0, DEPTH - 1), 8'($urandom), 1'b1, 1'b0);
      load_byte(i, 8'($urandom), i == DEPTH - 1, 1'b1);
    end
    check("full_load_run", (m_state == M_RUN) ? 1 : 0, 1);

    // Directed program load; bytes above 3 survive from the fill.
    do_reset();
    load_byte(0, 8'h89, 1'b0, 1'b1);
    load_byte(1, 8'hC8, 1'b0, 1'b1);
    load_byte(2, 8'h01, 1'b0, 1'b1);
    load_byte(3, 8'hC8, 1'b1, 1'b1);
    bus_op(32'd1, 32'd0, 1'b1, 1'b0, seen);
    check("unaligned_lo", seen[23:0], 24'hC801C8);

    bus_op(32'd8, 32'hDEADBEEF, 1'b0, 1'b1, seen);
    bus_op(32'd9, 32'd0, 1'b1, 1'b0, seen);
    check("wr_rd_lo", seen[23:0], 24'hDEADBE);

    // Randomized traffic; after an error, reset and reload a few bytes.
    for (int it = 0; it < 3000; it++) begin
      if (m_state == M_ERR) begin
        if ($urandom_range(0, 3) == 0) begin
          int k = $urandom_range(1, 6);
          do_reset();
          for (int j = 0; j < k; j++)
            load_byte($urandom_range(0, DEPTH - 1), 8'($urandom), j == k - 1, 1'b1);
        end else begin
          random_op();
        end
      end else begin
        random_op();
      end
    end

    // Range fault at the first out-of-range address, then a blocked write.
    do_reset();
    load_byte(100, 8'h5A, 1'b1, 1'b1);
    bus_op(32'(DEPTH - 3), 32'd0, 1'b1, 1'b0, seen);
    check("range_bus_in", seen, 0);
    check("range_err_code", err_code, 1);
    bus_op(32'd0, 32'h1234_5678, 1'b0, 1'b1, seen);
    do_reset();
    load_byte(100, 8'hA5, 1'b1, 1'b1);
    bus_op(32'd0, 32'd0, 1'b1, 1'b0, seen);

    // Collision, then reset releases the error.
    bus_op(32'd0, 32'hCAFE_F00D, 1'b1, 1'b1, seen);
    check("coll_err_code", err_code, 2);
    do_reset();
    check("coll_rst_err", err, 0);
    load_byte(200, 8'h11, 1'b1, 1'b1);
    bus_op(32'd0, 32'd0, 1'b1, 1'b0, seen);

`ifdef Y86_MEM_STATS_EN
    do_reset();
    load_byte(300, 8'h22, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) bus_op(32'(4 * i), 32'd0, 1'b1, 1'b0, seen);
    for (int i = 0; i < 2; i++) bus_op(32'(40 + i), $urandom, 1'b0, 1'b1, seen);
    bus_op(32'(DEPTH - 1), 32'd0, 1'b1, 1'b0, seen);
    check("stats_rd", rd_count, 3);
    check("stats_wr", wr_count, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
